// File: rtl/bsg_print_stat_multi_snoop_pkg.sv
// Shared definitions for the multi-link print-stat snoop: default EPA, event layout, width helper.
package bsg_print_stat_multi_snoop_pkg;

    localparam logic [27:0] print_stat_epa_gp = 28'h000_0D0C;

    // Event layout at default widths; the top builds the same {ts, link_id, tag} packing from its parameters.
    typedef struct packed {
        logic [31:0] ts;
        logic [0:0]  link_id;
        logic [31:0] tag;
    } bsg_print_stat_event_s;

    // Link-id width, never zero so a single-link build still has a field.
    function automatic int safe_lg(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Generic small FIFO: one write, one read port, head shown combinationally.
// Latency: push visible at the head the cycle after. Backpressure: push ignored when full.
// Head entry is consumed with yumi; yumi on an empty FIFO is ignored.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_vld,
    input  logic [width_p-1:0] push_dat,
    output logic               full,
    output logic               pop_vld,
    output logic [width_p-1:0] pop_dat,
    input  logic               yumi
);
    localparam int aw = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cw = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [aw-1:0]      wptr, rptr;
    logic [cw-1:0]      count;
    logic               do_push, do_pop;

    assign full    = (count == cw'(els_p));
    assign pop_vld = (count != '0);
    assign pop_dat = mem[rptr];
    assign do_push = push_vld & ~full;
    assign do_pop  = yumi & pop_vld;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= (wptr == aw'(els_p - 1)) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == aw'(els_p - 1)) ? '0 : rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bsg_print_stat_multi_snoop_slot.sv
// Per-link print-stat hit decode with a one-entry holding slot.
// Latency: hit captured at end of its cycle. Backpressure: a hit into an occupied, undrained slot is dropped.
module bsg_print_stat_multi_snoop_slot #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32,
    parameter int ts_width_p   = 32,
    parameter int link_w_p     = 1,
    parameter logic [link_w_p-1:0]     link_id_p = '0,
    parameter logic [addr_width_p-1:0] epa_p     = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      pkt_vld,
    input  logic                                      pkt_store,
    input  logic [addr_width_p-1:0]                   pkt_addr,
    input  logic [data_width_p-1:0]                   pkt_dat,
    input  logic [ts_width_p-1:0]                     ts,
    input  logic                                      drain,
    output logic                                      occupied,
    output logic [ts_width_p+link_w_p+data_width_p-1:0] entry,
    output logic                                      drop
);
    logic hit;

    assign hit  = en & pkt_vld & pkt_store & (pkt_addr == epa_p);
    assign drop = hit & occupied & ~drain;

    // A slot being drained this cycle frees up in time to take the same-cycle hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupied <= 1'b0;
            entry    <= '0;
        end else if (hit && (!occupied || drain)) begin
            occupied <= 1'b1;
            entry    <= {ts, link_id_p, pkt_dat};
        end else if (drain) begin
            occupied <= 1'b0;
        end
    end

endmodule

// File: rtl/bsg_print_stat_multi_snoop.sv
// Snoops N link channels for print-stat stores, timestamps and queues them for the host.
// Latency: hit in t shows at v_o in t+2. Backpressure: full FIFO stalls slots; further hits are counted as drops.
module bsg_print_stat_multi_snoop
    import bsg_print_stat_multi_snoop_pkg::*;
#(
    parameter int num_links_p      = 2,
    parameter int addr_width_p     = 28,
    parameter int data_width_p     = 32,
    parameter logic [addr_width_p-1:0] print_stat_epa_p = print_stat_epa_gp,
    parameter int fifo_els_p       = 8,
    parameter int ts_width_p       = 32,
    parameter int drop_ctr_width_p = 16,
    localparam int lw_lp = safe_lg(num_links_p),
    localparam int ew_lp = ts_width_p + lw_lp + data_width_p
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 en_i,
    input  logic [num_links_p-1:0]               pkt_v_i,
    input  logic [num_links_p-1:0]               pkt_store_i,
    input  logic [num_links_p*addr_width_p-1:0]  pkt_addr_i,
    input  logic [num_links_p*data_width_p-1:0]  pkt_data_i,
    output logic                                 v_o,
    output logic [ew_lp-1:0]                     data_o,
    input  logic                                 yumi_i,
    output logic [drop_ctr_width_p-1:0]          drop_count_o,
    output logic                                 overflow_o,
    input  logic                                 clear_i
);
    localparam logic [drop_ctr_width_p-1:0] drop_max_lp = '1;

    logic [ts_width_p-1:0]  ts_cnt;
    logic [num_links_p-1:0] occupied, drain, drops;
    logic [ew_lp-1:0]       slot_entry [num_links_p];
    logic [lw_lp-1:0]       rr_ptr, grant_idx;
    logic                   grant_found, grant_vld, fifo_full;
    logic [31:0]            drop_pop;
    logic [32:0]            drop_sum;
    logic [drop_ctr_width_p-1:0] drop_next;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 1'b1;
    end

    for (genvar k = 0; k < num_links_p; k++) begin : g_slot
        bsg_print_stat_multi_snoop_slot #(
            .addr_width_p (addr_width_p),
            .data_width_p (data_width_p),
            .ts_width_p   (ts_width_p),
            .link_w_p     (lw_lp),
            .link_id_p    (lw_lp'(k)),
            .epa_p        (print_stat_epa_p)
        ) u_slot (
            .clk       (clk_i),
            .rst_n     (reset_i),
            .en        (en_i),
            .pkt_vld   (pkt_v_i[k]),
            .pkt_store (pkt_store_i[k]),
            .pkt_addr  (pkt_addr_i[k*addr_width_p +: addr_width_p]),
            .pkt_dat   (pkt_data_i[k*data_width_p +: data_width_p]),
            .ts        (ts_cnt),
            .drain     (drain[k]),
            .occupied  (occupied[k]),
            .entry     (slot_entry[k]),
            .drop      (drops[k])
        );
    end

    // Round-robin: first occupied slot at or after the pointer wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < num_links_p; i++) begin
            int j;
            j = (int'(rr_ptr) + i) % num_links_p;
            if (!grant_found && occupied[j]) begin
                grant_found = 1'b1;
                grant_idx   = lw_lp'(j);
            end
        end
        grant_vld = grant_found & ~fifo_full;
        drain     = '0;
        if (grant_vld) drain[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)       rr_ptr <= '0;
        else if (grant_vld) rr_ptr <= (grant_idx == lw_lp'(num_links_p - 1)) ? '0 : grant_idx + 1'b1;
    end

    bsg_fifo_1r1w_small #(
        .width_p (ew_lp),
        .els_p   (fifo_els_p)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .push_vld (grant_vld),
        .push_dat (slot_entry[grant_idx]),
        .full     (fifo_full),
        .pop_vld  (v_o),
        .pop_dat  (data_o),
        .yumi     (yumi_i)
    );

    // Clear restarts from zero, but any same-cycle drops still land on top of it.
    always_comb begin
        drop_pop = '0;
        for (int i = 0; i < num_links_p; i++) drop_pop = drop_pop + 32'(drops[i]);
        drop_sum  = (clear_i ? 33'd0 : 33'(drop_count_o)) + 33'(drop_pop);
        drop_next = (drop_sum > 33'(drop_max_lp)) ? drop_max_lp : drop_sum[drop_ctr_width_p-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (clear_i || (|drops)) begin
            drop_count_o <= drop_next;
            overflow_o   <= (|drops) | (overflow_o & ~clear_i);
        end
    end

endmodule
